// File: rtl/audio_clip_sequencer.sv
// Clip playback sequencer: arbitrates play requests, walks the shared sample ROM at the
// audio tick rate and hands each sample to Audio_Controller through its write handshake.
module audio_clip_sequencer #(
  parameter int NUM_CLIPS = 4,
  parameter int ADDR_W    = 23,
  parameter int SAMPLE_W  = 16,
  parameter int TICK_DIV  = 2272,
  parameter int ROM_LAT   = 2,
  parameter int OUT_SHIFT = 14
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic [NUM_CLIPS-1:0]        play_req,
  input  logic [NUM_CLIPS-1:0]        loop_en,
  input  logic                        stop,
  input  logic [NUM_CLIPS*ADDR_W-1:0] clip_start,
  input  logic [NUM_CLIPS*ADDR_W-1:0] clip_end,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [SAMPLE_W-1:0]         rom_q,
  input  logic                        audio_out_allowed,
  output logic                        write_audio_out,
  output logic [31:0]                 left_channel_audio_out,
  output logic [31:0]                 right_channel_audio_out,
  output logic                        busy,
  output logic [2:0]                  active_clip,
  output logic                        clip_done,
  output logic                        overrun
);

  localparam int CNT_W  = $clog2(TICK_DIV + 1);
  localparam int WAIT_W = (ROM_LAT < 1) ? 1 : $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, HOLD} state_t;

  state_t                state, state_n;
  logic [CNT_W-1:0]      tick_cnt;
  logic                  tick;
  logic [NUM_CLIPS-1:0]  pending, pend_clr;
  logic [WAIT_W-1:0]     wait_cnt, wait_n;
  logic [SAMPLE_W-1:0]   sample_reg;
  logic [ADDR_W-1:0]     addr_n, first_start, act_start, act_end;
  logic [2:0]            clip_n, first_idx, grant_idx;
  logic                  act_pending, act_loop, grant, load_sample, ovr_set;
  logic signed [31:0]    sample_ext;

  // Lowest pending index wins; also pick out the active clip's bounds and flags.
  always_comb begin
    tick        = (tick_cnt == CNT_W'(TICK_DIV));
    first_idx   = '0;
    first_start = '0;
    act_start   = '0;
    act_end     = '0;
    act_pending = 1'b0;
    act_loop    = 1'b0;
    for (int i = NUM_CLIPS - 1; i >= 0; i--) begin
      if (pending[i]) first_idx = 3'(i);
    end
    for (int i = 0; i < NUM_CLIPS; i++) begin
      if (3'(i) == first_idx) first_start = clip_start[i*ADDR_W +: ADDR_W];
      if (3'(i) == active_clip) begin
        act_start   = clip_start[i*ADDR_W +: ADDR_W];
        act_end     = clip_end[i*ADDR_W +: ADDR_W];
        act_pending = pending[i];
        act_loop    = loop_en[i];
      end
    end
  end

  always_comb begin
    state_n         = state;
    addr_n          = rom_addr;
    clip_n          = active_clip;
    wait_n          = wait_cnt;
    grant           = 1'b0;
    grant_idx       = first_idx;
    load_sample     = 1'b0;
    write_audio_out = 1'b0;
    clip_done       = 1'b0;
    ovr_set         = 1'b0;
    pend_clr        = '0;
    // stop beats every other event, including a same-clock tick or grant
    if (stop) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            grant   = 1'b1;
            clip_n  = first_idx;
            addr_n  = first_start;
            wait_n  = '0;
            state_n = FETCH;
          end
        end
        FETCH: begin
          if (wait_cnt == WAIT_W'(ROM_LAT)) begin
            load_sample = 1'b1;
            state_n     = PRESENT;
          end else begin
            wait_n = wait_cnt + WAIT_W'(1);
          end
        end
        PRESENT, HOLD: begin
          if (tick) begin
            ovr_set = (state == PRESENT);
            wait_n  = '0;
            state_n = FETCH;
            if ((|pending) && (first_idx < active_clip)) begin
              grant  = 1'b1;
              clip_n = first_idx;
              addr_n = first_start;
            end else if (act_pending) begin
              grant     = 1'b1;
              grant_idx = active_clip;
              addr_n    = act_start;
            end else if (rom_addr != act_end) begin
              addr_n = rom_addr + ADDR_W'(1);
            end else if (act_loop) begin
              addr_n = act_start;
            end else begin
              clip_done = 1'b1;
              state_n   = IDLE;
            end
          end else if ((state == PRESENT) && audio_out_allowed) begin
            write_audio_out = 1'b1;
            state_n         = HOLD;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    for (int i = 0; i < NUM_CLIPS; i++) begin
      pend_clr[i] = grant && (3'(i) == grant_idx);
    end
    if (reset) begin
      write_audio_out = 1'b0;
      clip_done       = 1'b0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      pending     <= '0;
      wait_cnt    <= '0;
      sample_reg  <= '0;
      rom_addr    <= '0;
      active_clip <= '0;
      overrun     <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick ? '0 : tick_cnt + CNT_W'(1);
      // A request landing on its own grant clock survives the clear
      pending     <= (pending & ~pend_clr) | play_req;
      wait_cnt    <= wait_n;
      rom_addr    <= addr_n;
      active_clip <= clip_n;
      if (load_sample) sample_reg <= rom_q;
      if (ovr_set) overrun <= 1'b1;
    end
  end

  assign sample_ext              = 32'(signed'(sample_reg));
  assign left_channel_audio_out  = sample_ext <<< OUT_SHIFT;
  assign right_channel_audio_out = left_channel_audio_out;
  assign busy                    = (state != IDLE);

endmodule

// File: tb/tb_audio_clip_sequencer.sv
// Directed self-checking bench for audio_clip_sequencer with a 2-clock-latency ROM model.
module tb_audio_clip_sequencer;

  localparam int NC     = 4;
  localparam int AW     = 23;
  localparam int SW     = 16;
  localparam int TDIV   = 2272;
  localparam int PERIOD = TDIV + 1;

  logic           CLOCK_50, reset, stop, audio_out_allowed;
  logic [NC-1:0]  play_req, loop_en;
  logic [NC*AW-1:0] clip_start, clip_end;
  logic [AW-1:0]  rom_addr;
  logic [SW-1:0]  rom_q, rom_p1;
  logic           write_audio_out, busy, clip_done, overrun;
  logic [31:0]    left_channel_audio_out, right_channel_audio_out;
  logic [2:0]     active_clip;

  int checks = 0, failures = 0;
  int cyc = 0, tb_cnt = 0;
  int done_cnt = 0, done_clip = -1, done_cyc = 0;
  int wr_addr[$], wr_clip[$], wr_cyc[$];
  logic [31:0] wr_left[$];
  int base, dbase;

  audio_clip_sequencer #(
    .NUM_CLIPS(NC), .ADDR_W(AW), .SAMPLE_W(SW), .TICK_DIV(TDIV), .ROM_LAT(2), .OUT_SHIFT(14)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .play_req(play_req), .loop_en(loop_en), .stop(stop),
    .clip_start(clip_start), .clip_end(clip_end), .rom_addr(rom_addr), .rom_q(rom_q),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_channel_audio_out),
    .right_channel_audio_out(right_channel_audio_out),
    .busy(busy), .active_clip(active_clip), .clip_done(clip_done), .overrun(overrun)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  function automatic logic [15:0] rom_val(input int a);
    return 16'(a * 1000 - 15000);
  endfunction

  function automatic logic [31:0] exp_out(input int a);
    logic signed [15:0] s;
    s = rom_val(a);
    return 32'(s) * 32'sd16384;
  endfunction

  function automatic int wa(input int k);
    return (k < wr_addr.size()) ? wr_addr[k] : -1;
  endfunction
  function automatic int wc(input int k);
    return (k < wr_clip.size()) ? wr_clip[k] : -1;
  endfunction
  function automatic int wt(input int k);
    return (k < wr_cyc.size()) ? wr_cyc[k] : -1;
  endfunction
  function automatic logic [31:0] wl(input int k);
    return (k < wr_left.size()) ? wr_left[k] : 32'hDEADBEEF;
  endfunction

  // Two-stage ROM: data for an address appears two clocks after the address.
  always @(posedge CLOCK_50) begin
    rom_p1 <= rom_val(int'(rom_addr));
    rom_q  <= rom_p1;
  end

  always @(posedge CLOCK_50) begin
    cyc <= cyc + 1;
    if (reset) tb_cnt <= 0;
    else tb_cnt <= (tb_cnt == TDIV) ? 0 : tb_cnt + 1;
  end

  always @(negedge CLOCK_50) begin
    if (write_audio_out) begin
      wr_addr.push_back(int'(rom_addr));
      wr_clip.push_back(int'(active_clip));
      wr_cyc.push_back(cyc);
      wr_left.push_back(left_channel_audio_out);
    end
    if (clip_done) begin
      done_cnt++;
      done_clip = int'(active_clip);
      done_cyc  = cyc;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [NC-1:0] req, input logic stp);
    @(posedge CLOCK_50); #1;
    play_req = req;
    stop     = stp;
    @(posedge CLOCK_50); #1;
    play_req = '0;
    stop     = 1'b0;
  endtask

  task automatic syncTo(input int target);
    int k = 0;
    while (tb_cnt != target && k < PERIOD + 5) begin
      @(posedge CLOCK_50); #1; k++;
    end
  endtask

  task automatic waitWrites(input int n, input int budget, input string tag);
    int k = 0;
    while (wr_addr.size() < n && k < budget) begin
      @(posedge CLOCK_50); #1; k++;
    end
    checkOutput(tag, wr_addr.size(), n);
  endtask

  task automatic waitDone(input int n, input int budget, input string tag);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge CLOCK_50); #1; k++;
    end
    checkOutput(tag, done_cnt, n);
  endtask

  initial begin
    #(20 * 150000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; stop = 1'b0; play_req = '0; loop_en = '0; audio_out_allowed = 1'b1;
    clip_start = {23'd40, 23'd30, 23'd20, 23'd10};
    clip_end   = {23'd43, 23'd39, 23'd21, 23'd12};
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    checkOutput("rst_addr", 32'(rom_addr), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_write", 32'(write_audio_out), 0);
    checkOutput("rst_left", left_channel_audio_out, 0);
    checkOutput("rst_overrun", 32'(overrun), 0);
    checkOutput("rst_clip", 32'(active_clip), 0);
    @(posedge CLOCK_50); #1;
    reset = 1'b0;

    $display("[TB] T1 single clip 10..12");
    base = wr_addr.size(); dbase = done_cnt;
    syncTo(10);
    applyStimulus(4'b0001, 1'b0);
    waitWrites(base + 3, 3 * PERIOD + 100, "t1_writes");
    for (int k = 0; k < 3; k++) begin
      checkOutput("t1_addr", wa(base + k), 10 + k);
      checkOutput("t1_data", wl(base + k), exp_out(10 + k));
    end
    checkOutput("t1_spacing", wt(base + 2) - wt(base + 1), PERIOD);
    waitDone(dbase + 1, PERIOD + 100, "t1_done");
    checkOutput("t1_done_clip", done_clip, 0);
    @(posedge CLOCK_50); #1;
    checkOutput("t1_busy", 32'(busy), 0);

    $display("[TB] T2 looping clip 20..21");
    loop_en = 4'b0010;
    base = wr_addr.size(); dbase = done_cnt;
    syncTo(10);
    applyStimulus(4'b0010, 1'b0);
    waitWrites(base + 4, 4 * PERIOD + 100, "t2_writes");
    checkOutput("t2_addr0", wa(base), 20);
    checkOutput("t2_addr1", wa(base + 1), 21);
    checkOutput("t2_addr2", wa(base + 2), 20);
    checkOutput("t2_addr3", wa(base + 3), 21);
    checkOutput("t2_data1", wl(base + 1), exp_out(21));
    applyStimulus(4'b0000, 1'b1);
    checkOutput("t2_busy_stop", 32'(busy), 0);
    checkOutput("t2_no_done", done_cnt, dbase);

    $display("[TB] T3 preemption of clip2 by clip0");
    base = wr_addr.size(); dbase = done_cnt;
    syncTo(10);
    applyStimulus(4'b0100, 1'b0);
    waitWrites(base + 1, PERIOD, "t3_first");
    checkOutput("t3_addr0", wa(base), 30);
    applyStimulus(4'b0001, 1'b0);
    waitWrites(base + 2, PERIOD + 100, "t3_preempt");
    checkOutput("t3_pre_addr", wa(base + 1), 10);
    checkOutput("t3_pre_clip", wc(base + 1), 0);
    checkOutput("t3_right", right_channel_audio_out, exp_out(10));
    waitWrites(base + 4, 2 * PERIOD + 100, "t3_rest");
    checkOutput("t3_addr3", wa(base + 3), 12);
    waitDone(dbase + 1, PERIOD + 100, "t3_done");
    checkOutput("t3_done_clip", done_clip, 0);
    repeat (10) @(posedge CLOCK_50); #1;
    checkOutput("t3_no_resume", 32'(busy), 0);
    checkOutput("t3_count", wr_addr.size(), base + 4);

    $display("[TB] T4 backpressure overrun");
    checkOutput("t4_ovr_pre", 32'(overrun), 0);
    base = wr_addr.size(); dbase = done_cnt;
    syncTo(10);
    applyStimulus(4'b1000, 1'b0);
    waitWrites(base + 1, PERIOD, "t4_first");
    checkOutput("t4_addr0", wa(base), 40);
    audio_out_allowed = 1'b0;
    begin
      int k = 0;
      while (overrun !== 1'b1 && k < 2 * PERIOD + 100) begin
        @(posedge CLOCK_50); #1; k++;
      end
    end
    audio_out_allowed = 1'b1;
    checkOutput("t4_overrun", 32'(overrun), 1);
    waitWrites(base + 2, 100, "t4_resume");
    checkOutput("t4_skip_addr", wa(base + 1), 42);
    checkOutput("t4_skip_data", wl(base + 1), exp_out(42));
    waitDone(dbase + 1, 2 * PERIOD + 100, "t4_done");
    checkOutput("t4_ovr_sticky", 32'(overrun), 1);

    $display("[TB] T5 stop coincident with tick");
    base = wr_addr.size(); dbase = done_cnt;
    syncTo(10);
    applyStimulus(4'b0010, 1'b0);
    waitWrites(base + 1, PERIOD, "t5_first");
    checkOutput("t5_addr0", wa(base), 20);
    applyStimulus(4'b1000, 1'b0);
    syncTo(TDIV);
    stop = 1'b1;
    @(posedge CLOCK_50); #1;
    stop = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_no_done", done_cnt, dbase);
    waitWrites(base + 2, 100, "t5_next");
    checkOutput("t5_next_addr", wa(base + 1), 40);
    checkOutput("t5_next_clip", wc(base + 1), 3);
    applyStimulus(4'b0000, 1'b1);

    $display("[TB] T6 simultaneous requests");
    loop_en = 4'b0000;
    base = wr_addr.size(); dbase = done_cnt;
    syncTo(10);
    applyStimulus(4'b0011, 1'b0);
    waitWrites(base + 3, 3 * PERIOD + 100, "t6_clip0");
    checkOutput("t6_first_clip", wc(base), 0);
    waitDone(dbase + 1, PERIOD + 100, "t6_done");
    checkOutput("t6_done_idle", 32'(busy), 0);
    @(posedge CLOCK_50); #1;
    checkOutput("t6_grant_busy", 32'(busy), 1);
    checkOutput("t6_grant_clip", 32'(active_clip), 1);
    checkOutput("t6_grant_addr", 32'(rom_addr), 20);
    waitWrites(base + 4, 100, "t6_clip1");
    checkOutput("t6_c1_addr", wa(base + 3), 20);
    checkOutput("t6_c1_latency", wt(base + 3) - done_cyc, 5);

    $display("[TB] reset mid-clip");
    applyStimulus(4'b1000, 1'b0);
    base = wr_addr.size();
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    @(posedge CLOCK_50); #1;
    reset = 1'b0;
    checkOutput("rst2_busy", 32'(busy), 0);
    checkOutput("rst2_addr", 32'(rom_addr), 0);
    repeat (10) @(posedge CLOCK_50); #1;
    checkOutput("rst2_pending_lost", 32'(busy), 0);
    checkOutput("rst2_no_write", wr_addr.size(), base);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
